// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared types and helpers for the producer stream controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int c_parity_w = 256;

    function automatic logic even_parity(input logic [c_parity_w-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word fall-through head.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNTW  = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    localparam logic [CNTW-1:0] c_full_lvl = CNTW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;

    // The caller only pushes when not full (or when popping the same cycle)
    // and only pops when not empty; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_full_lvl);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stream_ctrl
// Description : Selects and enables one producer, buffers its words with
//               hysteresis back-pressure and presents them with even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_ctrl
    import stream_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 8,
    localparam int CHW    = $clog2(NUM_CH),
    localparam int CNTW   = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CHW-1:0]          start_ch,
    input  logic                    stop,
    output logic [NUM_CH-1:0]       prod_en,
    input  logic [NUM_CH-1:0]       prod_valid,
    input  logic [NUM_CH*WIDTH-1:0] prod_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_parity,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [CHW-1:0]          active_ch,
    output logic [CNTW-1:0]         fifo_count
);

    localparam logic [CHW:0]    c_num_ch     = (CHW+1)'(NUM_CH);
    localparam logic [CNTW-1:0] c_pause_lvl  = CNTW'(DEPTH - 1);
    localparam logic [CNTW-1:0] c_resume_lvl = CNTW'(DEPTH / 2);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CHW-1:0]    r_active_ch;
    logic [CHW-1:0]    w_active_nxt;
    logic [NUM_CH-1:0] r_prod_en;
    logic [NUM_CH-1:0] w_prod_en_nxt;

    logic              w_sel_valid;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNTW-1:0]   w_count;
    logic [CNTW-1:0]   w_count_nxt;
    logic [WIDTH-1:0]  w_head;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_active_ch == CHW'(i)) begin
                w_sel_valid = prod_valid[i];
                w_sel_data  = prod_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accepting while full is fine when the head leaves in the same cycle.
    assign w_pop  = !w_empty && out_ready;
    assign w_push = w_sel_valid && (r_state != IDLE) && (!w_full || w_pop);

    always_comb begin
        w_count_nxt = w_count;
        if (w_push && !w_pop) begin
            w_count_nxt = w_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = w_count - 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_sel_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Pausing at DEPTH-1 leaves one slot for the word already in flight
    // from a producer with one cycle of enable-to-valid latency.
    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active_ch;
        w_prod_en_nxt = '0;
        case (r_state)
            IDLE: begin
                if (start && ({1'b0, start_ch} < c_num_ch)) begin
                    w_state_nxt  = RUN;
                    w_active_nxt = start_ch;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = DRAIN;
                end else if (w_count_nxt >= c_pause_lvl) begin
                    w_state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    w_state_nxt = DRAIN;
                end else if (w_count <= c_resume_lvl) begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            w_prod_en_nxt[i] = (w_state_nxt == RUN) && (w_active_nxt == CHW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_active_ch <= '0;
            r_prod_en   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_active_ch <= w_active_nxt;
            r_prod_en   <= w_prod_en_nxt;
        end
    end

    assign prod_en    = r_prod_en;
    assign busy       = (r_state != IDLE);
    assign active_ch  = r_active_ch;
    assign fifo_count = w_count;
    assign out_valid  = !w_empty;
    assign out_data   = w_head;
    assign out_parity = even_parity(c_parity_w'(w_head));

endmodule
`default_nettype wire

// File: tb/tb_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_ctrl
// Description : Self-checking bench for stream_ctrl against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_ctrl;

    localparam int NCH = 3;
    localparam int W   = 16;
    localparam int D   = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       start_ch;
    logic             stop;
    logic [NCH-1:0]   prod_en;
    logic [NCH-1:0]   prod_valid;
    logic [NCH*W-1:0] prod_data;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_parity;
    logic             out_ready;
    logic             busy;
    logic [1:0]       active_ch;
    logic [3:0]       fifo_count;

    stream_ctrl #(.NUM_CH(NCH), .WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_ch   (start_ch),
        .stop       (stop),
        .prod_en    (prod_en),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_ready  (out_ready),
        .busy       (busy),
        .active_ch  (active_ch),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {M_OFF, M_STREAM, M_HOLD, M_FLUSH} mode_t;

    mode_t        m_mode;
    int           m_act;
    logic [NCH-1:0] m_en;
    logic [W-1:0] m_q[$];
    logic [W-1:0] cap_d[$];
    logic         cap_p[$];

    int           n_vec;
    int           n_err;
    bit           chk_on;
    int           gen;
    int           budget;
    int           gate_pct;
    bit           noise;
    logic [NCH-1:0] en_prev;
    logic [W-1:0] ctr [NCH];

    task automatic report(input string nm, input int got, input int want);
        n_err++;
        $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    endtask

    task automatic lit(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) report(nm, got, want);
    endtask

    // Reference: occupancy and mode follow directly from the stream rules.
    always @(posedge clk) begin : model
        int sz;
        int nxt;
        bit po;
        bit pu;
        logic [W-1:0] wd;
        if (rst) begin
            m_q.delete();
            m_mode = M_OFF;
            m_act  = 0;
            m_en   = '0;
        end else begin
            sz  = m_q.size();
            po  = (sz > 0) && out_ready;
            pu  = (m_mode != M_OFF) && prod_valid[m_act] && (sz < D || po);
            wd  = prod_data[m_act*W +: W];
            nxt = sz + int'(pu) - int'(po);
            case (m_mode)
                M_OFF:    if (start && int'(start_ch) < NCH) begin
                              m_mode = M_STREAM;
                              m_act  = int'(start_ch);
                          end
                M_STREAM: if (stop) m_mode = M_FLUSH;
                          else if (nxt >= D - 1) m_mode = M_HOLD;
                M_HOLD:   if (stop) m_mode = M_FLUSH;
                          else if (sz <= D / 2) m_mode = M_STREAM;
                M_FLUSH:  if (sz == 0) m_mode = M_OFF;
                default:  m_mode = M_OFF;
            endcase
            m_en = (m_mode == M_STREAM) ? NCH'(1 << m_act) : '0;
            if (po) void'(m_q.pop_front());
            if (pu) m_q.push_back(wd);
        end
    end

    always @(posedge clk) begin : capture
        if (!rst && out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_p.push_back(out_parity);
        end
    end

    always @(negedge clk) begin : compare
        if (chk_on) begin
            n_vec++;
            if (busy !== (m_mode != M_OFF)) report("busy", int'(busy), int'(m_mode != M_OFF));
            if (active_ch !== 2'(m_act)) report("active_ch", int'(active_ch), m_act);
            if (prod_en !== m_en) report("prod_en", int'(prod_en), int'(m_en));
            if (fifo_count !== 4'(m_q.size())) report("fifo_count", int'(fifo_count), m_q.size());
            if (out_valid !== (m_q.size() > 0)) report("out_valid", int'(out_valid), int'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                if (out_data !== m_q[0]) report("out_data", int'(out_data), int'(m_q[0]));
                if (out_parity !== ^m_q[0]) report("out_parity", int'(out_parity), int'(^m_q[0]));
            end
        end
    end

    // Producers answer an enable with valid one cycle later.
    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            prod_valid[i]       = 1'b0;
            prod_data[i*W +: W] = W'($urandom);
            if (gen == 2 || (gen == 1 && en_prev[i] && budget > 0 &&
                             int'($urandom_range(99)) < gate_pct)) begin
                prod_valid[i]       = 1'b1;
                prod_data[i*W +: W] = ctr[i];
                ctr[i]              = ctr[i] + 1'b1;
                if (gen == 1) budget--;
            end else if (gen == 1 && noise && !en_prev[i] && $urandom_range(3) == 0) begin
                prod_valid[i] = 1'b1;
            end
        end
        en_prev = prod_en;
    endtask

    task automatic wait_cnt(input int want, input int bound, input string nm);
        int k;
        k = 0;
        while (int'(fifo_count) != want && k < bound) begin
            cyc();
            k++;
        end
        lit(nm, int'(fifo_count), want);
    endtask

    task automatic finish_stream();
        int k;
        gen       = 0;
        out_ready = 1'b1;
        stop      = 1'b1;
        cyc();
        stop = 1'b0;
        k    = 0;
        while (busy && k < 40) begin
            cyc();
            k++;
        end
        lit("to_idle", int'(busy), 0);
    endtask

    task automatic begin_stream(input int ch);
        start    = 1'b1;
        start_ch = 2'(ch);
        cyc();
        start = 1'b0;
    endtask

    initial begin : main
        int k;
        int peak;
        n_vec = 0; n_err = 0; chk_on = 0;
        gen = 0; budget = 0; gate_pct = 100; noise = 0; en_prev = '0;
        for (int i = 0; i < NCH; i++) ctr[i] = W'(1);
        rst = 1'b1; start = 1'b0; start_ch = '0; stop = 1'b0; out_ready = 1'b0;
        prod_valid = '0; prod_data = '0;
        m_mode = M_OFF; m_act = 0; m_en = '0;
        cyc(); cyc();
        chk_on = 1;
        lit("rst_busy", int'(busy), 0);
        lit("rst_count", int'(fifo_count), 0);
        lit("rst_valid", int'(out_valid), 0);
        lit("rst_en", int'(prod_en), 0);
        lit("rst_act", int'(active_ch), 0);
        rst = 1'b0;

        // Basic stream from channel 1: words 1,2,3
        out_ready = 1'b1; gen = 1; budget = 3; gate_pct = 100;
        begin_stream(1);
        lit("basic_en", int'(prod_en), 2);
        k = 0;
        while (cap_d.size() < 3 && k < 20) begin cyc(); k++; end
        lit("basic_n", cap_d.size(), 3);
        if (cap_d.size() >= 3) begin
            lit("basic_w0", int'(cap_d[0]), 1);
            lit("basic_w1", int'(cap_d[1]), 2);
            lit("basic_w2", int'(cap_d[2]), 3);
            lit("basic_p0", int'(cap_p[0]), 1);
            lit("basic_p1", int'(cap_p[1]), 1);
            lit("basic_p2", int'(cap_p[2]), 0);
        end
        finish_stream();

        // Back-pressure and hysteresis
        out_ready = 1'b0; gen = 1; budget = 1000; gate_pct = 100;
        begin_stream(0);
        k = 0;
        while (prod_en != '0 && k < 30) begin cyc(); k++; end
        lit("bp_pause_cnt", int'(fifo_count), 7);
        peak = int'(fifo_count);
        repeat (6) begin
            cyc();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        lit("bp_peak", peak, 8);
        out_ready = 1'b1;
        k = 0;
        while (prod_en == '0 && k < 30) begin cyc(); k++; end
        lit("bp_resume_cnt", int'(fifo_count), 3);
        finish_stream();

        // Stop with five words buffered
        out_ready = 1'b0; gen = 1; budget = 5; gate_pct = 100;
        begin_stream(2);
        wait_cnt(5, 30, "drain_fill");
        cyc(); cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0; out_ready = 1'b1; gen = 0;
        k = 0;
        while (busy && k < 20) begin k++; cyc(); end
        lit("drain_busy_cycles", k, 6);
        lit("drain_en", int'(prod_en), 0);

        // Illegal and ignored starts
        begin_stream(3);
        lit("illegal_ch", int'(busy), 0);
        begin_stream(1);
        lit("start_ok", int'(active_ch), 1);
        begin_stream(2);
        lit("start_in_run", int'(active_ch), 1);
        finish_stream();
        start = 1'b1; stop = 1'b1; start_ch = 2'd2;
        cyc();
        start = 1'b0; stop = 1'b0;
        lit("start_stop_busy", int'(busy), 1);
        lit("start_stop_en", int'(prod_en), 4);
        finish_stream();

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0; gen = 2;
        begin_stream(0);
        wait_cnt(8, 30, "full_fill");
        cyc(); cyc();
        out_ready = 1'b1;
        repeat (10) begin
            cyc();
            lit("full_cnt", int'(fifo_count), 8);
        end
        finish_stream();

        // Twenty words through an eight-deep FIFO
        cap_d.delete(); cap_p.delete();
        ctr[1] = W'(1); gen = 1; budget = 20; gate_pct = 60; noise = 0;
        begin_stream(1);
        k = 0;
        while (cap_d.size() < 20 && k < 600) begin
            out_ready = ($urandom_range(9) < 7);
            cyc();
            k++;
        end
        lit("wrap_n", cap_d.size(), 20);
        for (int i = 0; i < cap_d.size() && i < 20; i++) lit("wrap_word", int'(cap_d[i]), i + 1);
        finish_stream();

        // Reset with six words buffered
        out_ready = 1'b0; gen = 1; budget = 6; gate_pct = 100;
        begin_stream(0);
        wait_cnt(6, 30, "rmr_fill");
        rst = 1'b1;
        cyc();
        rst = 1'b0; gen = 0;
        lit("rmr_count", int'(fifo_count), 0);
        lit("rmr_valid", int'(out_valid), 0);
        lit("rmr_busy", int'(busy), 0);
        lit("rmr_en", int'(prod_en), 0);

        // Randomised traffic
        noise = 1; gen = 1; budget = 1 << 30; gate_pct = 80;
        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 300) gen = 2;
            else if (c % 600 == 0) gen = 1;
            start     = ($urandom_range(19) == 0);
            start_ch  = 2'($urandom_range(3));
            stop      = ($urandom_range(39) == 0);
            out_ready = ($urandom_range(99) < 60);
            rst       = ($urandom_range(499) == 0);
            cyc();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(); cyc();
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_ctrl.md
# stream_ctrl

Parametrised producer-to-consumer stream controller: selects one of `NUM_CH` data producers (Fibonacci, timer, future generators) and enables it. Valid words are captured into an internal FIFO with hysteresis back-pressure, then presented to a ready/valid consumer with even parity. Sits between the producer blocks and the display/transport path, replacing hard-wired two-producer control FSMs.

## Interface
- `NUM_CH`, default 2: number of producer channels, at least 2.
- `WIDTH`, default 16: data word width.
- `DEPTH`, default 8: FIFO depth; power of two, at least 4.
- `CHW = $clog2(NUM_CH)`, `CNTW = $clog2(DEPTH)+1`: derived local widths.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: one-cycle request to begin streaming from `start_ch`.
- `start_ch` in CHW: channel index sampled with `start`.
- `stop` in 1: one-cycle request to end streaming and drain.
- `prod_en` out NUM_CH: one-hot enable to producers; registered.
- `prod_valid` in NUM_CH: per-producer data-valid strobe.
- `prod_data` in NUM_CH*WIDTH: packed producer data; channel i occupies bits [i*WIDTH +: WIDTH].
- `out_valid` out 1: FIFO head is valid.
- `out_data` out WIDTH: FIFO head word (first-word fall-through).
- `out_parity` out 1: XOR of all bits of `out_data`.
- `out_ready` in 1: consumer accepts the head when high together with `out_valid`.
- `busy` out 1: high whenever state is not IDLE.
- `active_ch` out CHW: channel currently latched.
- `fifo_count` out CNTW: current occupancy, 0..DEPTH.

## Operation
- States: IDLE, RUN, PAUSE, DRAIN.
- **IDLE**
  - `start` with `start_ch < NUM_CH`: latch `active_ch`, go to RUN.
  - `start` with `start_ch >= NUM_CH`: ignored.
  - `stop` alone: ignored.
  - `start` and `stop` in the same cycle: start wins.
- **RUN**
  - `prod_en[active_ch]=1`.
  - `stop` goes to DRAIN (priority).
  - Else go to PAUSE when the next-cycle occupancy is at least DEPTH-1.
- **PAUSE**
  - `prod_en=0`.
  - `stop` goes to DRAIN.
  - Else return to RUN when occupancy is at most DEPTH/2 (hysteresis).
- **DRAIN**
  - `prod_en=0`.
  - Go to IDLE when the FIFO is empty and no pop occurs that cycle.
- `start` outside IDLE is ignored; a new channel is never taken mid-stream.
- **Push**: occurs when `prod_valid[active_ch]` is high, state is not IDLE, and the FIFO is not full.
  - Covers the one in-flight word after `prod_en` falls.
  - Valids on non-active channels are ignored.
  - A push attempted while full is dropped. This cannot happen with compliant producers that have at most 1 cycle of enable-to-valid latency.
- **Pop**: occurs on `out_valid && out_ready`.
  - Simultaneous push and pop is legal at any occupancy, including full and empty-with-push.
  - Occupancy is unchanged in that case.
- Pointers wrap modulo DEPTH; `fifo_count` tracks 0..DEPTH exactly.
- **Reset values**: state IDLE, `prod_en=0`, `active_ch=0`, `busy=0`, `fifo_count=0`, `out_valid=0`. `out_data` and `out_parity` are don't-care while `out_valid=0`.
- `rst` mid-operation: FIFO contents discarded and all outputs return to reset values on the next edge.

## Timing
- Start to enable: `start` at edge N, state=RUN and `prod_en` high after edge N+1.
- Push to output: a word pushed at edge N appears on `out_data` with `out_valid` high after edge N (0-cycle read of an empty FIFO head through registers, i.e. visible in cycle N+1).
- Stop to disable: `stop` at edge N, `prod_en` low after edge N+1. A valid arriving in cycle N+1 is still accepted.
- Pause to disable: PAUSE is entered at the edge where the count reaches DEPTH-1, and `prod_en` is low one cycle later. Worst case is one further word, giving DEPTH, with no drop.
- `busy` and `active_ch` are registered and align with state.
- `out_parity` is combinational from `out_data`.

## Structure
- Package `stream_pkg`:
  - state enum (IDLE=0, RUN=1, PAUSE=2, DRAIN=3);
  - helper function for even parity.
- Sub-module `sync_fifo`, parameterised by WIDTH and DEPTH:
  - inputs: push, pop;
  - outputs: full, empty, count, head;
  - register array with wrap pointers.
- `stream_ctrl` holds the FSM, channel mux, enable register and hysteresis compare.

## Test plan
- **Basic stream**: reset; `start` with ch=1, NUM_CH=2, DEPTH=8; producer 1 emits 1,2,3 with `out_ready=1`.
  - Required: `prod_en=2'b10` one cycle after start.
  - Required: outputs 1,2,3 in order, with `out_parity` equal to 1,1,0 respectively.
- **Back-pressure**: `out_ready=0`, producer valid every cycle.
  - Required: PAUSE at count 7, `prod_en` drops, count peaks at 8, no loss.
  - Then `out_ready=1`: RUN resumes when count reaches 4.
- **Stop/drain**: 5 words buffered, then `stop`.
  - Required: DRAIN, `busy` stays high until 5 pops complete, then IDLE and `prod_en=0`.
- **Illegal and ignored starts**:
  - `start_ch=3` with NUM_CH=3 is ignored.
  - `start` during RUN is ignored; `active_ch` unchanged.
  - `start` and `stop` together in IDLE enter RUN.
- **Boundary**: full FIFO with simultaneous push and pop.
  - Required: count stays 8 and data order is preserved.
  - Wrap check: stream 20 words through DEPTH=8 in order.
- **Reset mid-run**: `rst` with 6 words buffered.
  - Required: next cycle count=0, `out_valid=0`, state IDLE, `prod_en=0`.
